wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 33 +++
 rtl/wb_arbiter_rr_select.sv | 13 +
 rtl/wb_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and the round-robin pick function for the Wishbone arbiter.
package wb_arbiter_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned ADR_W       = 32;
  localparam int unsigned DAT_W       = 32;
  localparam int unsigned SEL_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // First requester at or after (last+1) mod n, one-hot; zero when nobody requests.
  function automatic logic [MAX_MASTERS-1:0] rr_pick(
    input logic [MAX_MASTERS-1:0] req,
    input logic [2:0]             last,
    input int unsigned            n
  );
    logic [MAX_MASTERS-1:0] win;
    logic [2:0]             idx;
    win = '0;
    for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
      if (i <= n) begin
        idx = 3'((32'(last) + i) % n);
        if (req[idx] && (win == '0)) win[idx] = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_select.sv
// Round-robin selector: request vector plus last owner to a one-hot winner.
module rr_select import wb_arbiter_pkg::*; #(
  parameter int unsigned NUM_MASTERS = 2,
  localparam int unsigned IDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_owner,
  output logic [NUM_MASTERS-1:0] grant
);

  assign grant = NUM_MASTERS'(rr_pick(MAX_MASTERS'(req), 3'(last_owner), NUM_MASTERS));

endmodule

// File: rtl/wb_arbiter.sv
// N-master to 1-slave Wishbone pipelined arbiter with outstanding-request limit.
// Optional ack timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter import wb_arbiter_pkg::*; #(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [NUM_MASTERS*ADR_W-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DAT_W-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_W-1:0] m_sel_i,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_stall_o,
  output logic [DAT_W-1:0]             m_dat_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [ADR_W-1:0]             s_adr_o,
  output logic [DAT_W-1:0]             s_dat_o,
  output logic [SEL_W-1:0]             s_sel_o,
  input  logic [DAT_W-1:0]             s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_stall_i,
  output logic [NUM_MASTERS-1:0]       grant_o,
  output logic                         timeout_o
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t             state, state_nxt;
  logic [IDX_W-1:0]       last_owner, last_owner_nxt;
  logic [CNT_W-1:0]       count, count_nxt;
  logic [NUM_MASTERS-1:0] rr_grant;
  logic [IDX_W-1:0]       rr_idx;
  logic                   full, own_cyc, ack_ok, accept, tmo_fire;

  rr_select #(.NUM_MASTERS(NUM_MASTERS)) u_rr (
    .req        (m_cyc_i),
    .last_owner (last_owner),
    .grant      (rr_grant)
  );

  always_comb begin
    rr_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++)
      if (rr_grant[i]) rr_idx = IDX_W'(i);
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_fire = (count != '0) && !s_ack_i && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

  // Cycles waited for an ack while requests are outstanding.
  always_ff @(posedge clk_i) begin
    if (!rst_i || s_ack_i || (count == '0) || tmo_fire) tmo_cnt <= '0;
    else                                                  tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`else
  logic unused_tmo_cycles;
  assign unused_tmo_cycles = ^TIMEOUT_CYCLES;
  assign tmo_fire          = 1'b0;
`endif

  assign timeout_o = tmo_fire;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      count      <= '0;
      last_owner <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    count_nxt      = count;
    m_ack_o        = '0;
    m_stall_o      = '1;
    m_dat_o        = '0;
    s_cyc_o        = 1'b0;
    s_stb_o        = 1'b0;
    s_we_o         = 1'b0;
    s_adr_o        = '0;
    s_dat_o        = '0;
    s_sel_o        = '0;
    grant_o        = '0;
    full           = (count == CNT_W'(MAX_OUTSTANDING));
    own_cyc        = m_cyc_i[last_owner];
    ack_ok         = (s_ack_i || tmo_fire) && (count != '0);

    case (state)
      IDLE: begin
        if (|m_cyc_i) begin
          state_nxt      = OWNED;
          last_owner_nxt = rr_idx;
        end
      end
      OWNED: begin
        grant_o[last_owner]   = 1'b1;
        // Keep the slave cycle open for the drop cycle if requests are still in flight.
        s_cyc_o               = own_cyc || (count != '0);
        s_stb_o               = own_cyc && m_stb_i[last_owner] && !full;
        s_we_o                = m_we_i[last_owner];
        s_adr_o               = m_adr_i[ADR_W*32'(last_owner) +: ADR_W];
        s_dat_o               = m_dat_i[DAT_W*32'(last_owner) +: DAT_W];
        s_sel_o               = m_sel_i[SEL_W*32'(last_owner) +: SEL_W];
        m_stall_o[last_owner] = s_stall_i || full;
        m_ack_o[last_owner]   = ack_ok;
        m_dat_o               = tmo_fire ? '0 : s_dat_i;
        if (!own_cyc) state_nxt = (count == '0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        grant_o[last_owner] = 1'b1;
        s_cyc_o             = 1'b1;
        m_dat_o             = tmo_fire ? '0 : s_dat_i;
      end
      default: state_nxt = IDLE;
    endcase

    accept = s_stb_o && !s_stall_i;
    if (accept && !ack_ok)      count_nxt = count + CNT_W'(1);
    else if (!accept && ack_ok) count_nxt = count - CNT_W'(1);

    if ((state == DRAIN) && (count_nxt == '0)) state_nxt = IDLE;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (two instances: limit 2 and limit 4).
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
  logic [63:0] m_adr = '0, m_dat = '0;
  logic [7:0]  m_sel = '0;
  logic [31:0] s_dat_i = '0;
  logic        s_ack = 1'b0, s_stall = 1'b0;

  logic [1:0]  a_ack, a_stall, a_grant;
  logic [31:0] a_mdat, a_sadr, a_sdat;
  logic [3:0]  a_ssel;
  logic        a_scyc, a_sstb, a_swe, a_tmo;

  logic [1:0]  b_ack, b_stall, b_grant;
  logic [31:0] unused_b_mdat, unused_b_sadr, unused_b_sdat;
  logic [3:0]  unused_b_ssel;
  logic        b_scyc, b_sstb, unused_b_swe, b_tmo;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_MASTERS(2), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(8)) dut_a (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_ack_o(a_ack), .m_stall_o(a_stall), .m_dat_o(a_mdat),
    .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe),
    .s_adr_o(a_sadr), .s_dat_o(a_sdat), .s_sel_o(a_ssel),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_stall_i(s_stall),
    .grant_o(a_grant), .timeout_o(a_tmo)
  );

  wb_arbiter #(.NUM_MASTERS(2), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)) dut_b (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_ack_o(b_ack), .m_stall_o(b_stall), .m_dat_o(unused_b_mdat),
    .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(unused_b_swe),
    .s_adr_o(unused_b_sadr), .s_dat_o(unused_b_sdat), .s_sel_o(unused_b_ssel),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_stall_i(s_stall),
    .grant_o(b_grant), .timeout_o(b_tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with nonzero slave data to prove m_dat_o is gated.
    s_dat_i = 32'h1234_5678;
    tick();
    tick();
    settle();
    chk("rst_grant", 32'(a_grant), 32'h0);
    chk("rst_stall", 32'(a_stall), 32'h3);
    chk("rst_scyc",  32'(a_scyc), 32'h0);
    chk("rst_mdat",  a_mdat, 32'h0);
    chk("rst_count", 32'(dut_a.count), 32'h0);
    chk("rst_last",  32'(dut_a.last_owner), 32'h1);
    chk("rst_tmo",   32'(a_tmo), 32'h0);

    // Both masters request together: m0 wins, one IDLE cycle on handover to m1.
    tick();
    rst_i = 1'b1;
    m_cyc = 2'b11;
    settle();
    chk("arb_cycle_grant", 32'(a_grant), 32'h0);
    chk("arb_cycle_scyc",  32'(a_scyc), 32'h0);
    tick();
    settle();
    chk("own0_grant", 32'(a_grant), 32'h1);
    chk("own0_stall", 32'(a_stall), 32'h2);
    tick();
    m_cyc = 2'b10;
    settle();
    chk("own0_release_grant", 32'(a_grant), 32'h1);
    tick();
    settle();
    chk("handover_idle", 32'(a_grant), 32'h0);
    tick();
    settle();
    chk("handover_grant", 32'(a_grant), 32'h2);
    chk("handover_stall", 32'(a_stall), 32'h1);

    // m1 read returns DEADBEEF.
    m_stb = 2'b10;
    m_adr = {32'h0000_0100, 32'h0};
    m_dat = {32'h55AA_0FF0, 32'h0};
    m_sel = 8'hF0;
    settle();
    chk("rd_sstb", 32'(a_sstb), 32'h1);
    chk("rd_sadr", a_sadr, 32'h0000_0100);
    chk("rd_sdat", a_sdat, 32'h55AA_0FF0);
    chk("rd_ssel", 32'(a_ssel), 32'hF);
    chk("rd_swe",  32'(a_swe), 32'h0);
    tick();
    m_stb = 2'b00;
    s_ack = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    settle();
    chk("rd_count1", 32'(dut_a.count), 32'h1);
    chk("rd_ack",    32'(a_ack), 32'h2);
    chk("rd_mdat",   a_mdat, 32'hDEAD_BEEF);
    tick();
    s_ack = 1'b0;
    settle();
    chk("rd_count0", 32'(dut_a.count), 32'h0);
    chk("rd_ack_off", 32'(a_ack), 32'h0);

    // Accept and ack in the same cycle at count 1.
    m_stb = 2'b10;
    tick();
    s_ack = 1'b1;
    settle();
    chk("same_pre", 32'(dut_a.count), 32'h1);
    tick();
    m_stb = 2'b00;
    s_ack = 1'b0;
    settle();
    chk("same_cycle_count", 32'(dut_a.count), 32'h1);

    // Drain the last one, then an ack at count 0 is dropped.
    s_ack = 1'b1;
    tick();
    settle();
    chk("ack_at_zero_dropped", 32'(a_ack), 32'h0);
    tick();
    s_ack = 1'b0;
    settle();
    chk("no_underflow", 32'(dut_a.count), 32'h0);
    m_cyc = 2'b00;
    tick();

    // Outstanding limit of 2 with a silent slave.
    do_reset();
    m_cyc = 2'b01;
    m_stb = 2'b01;
    tick();
    settle();
    chk("lim_stb0", 32'(a_sstb), 32'h1);
    tick();
    settle();
    chk("lim_stb1", 32'(a_sstb), 32'h1);
    tick();
    settle();
    chk("lim_full_count", 32'(dut_a.count), 32'h2);
    chk("lim_full_stb",   32'(a_sstb), 32'h0);
    chk("lim_full_stall", 32'(a_stall), 32'h3);
    tick();
    settle();
    chk("lim_hold_count", 32'(dut_a.count), 32'h2);
    s_ack = 1'b1;
    settle();
    chk("lim_ack", 32'(a_ack), 32'h1);
    tick();
    s_ack = 1'b0;
    settle();
    chk("lim_release_count", 32'(dut_a.count), 32'h1);
    chk("lim_release_stb",   32'(a_sstb), 32'h1);
    tick();
    settle();
    chk("lim_refull_count", 32'(dut_a.count), 32'h2);
    chk("lim_refull_stb",   32'(a_sstb), 32'h0);

    // Reset with requests in flight; a late ack is dropped.
    rst_i = 1'b0;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    tick();
    rst_i = 1'b1;
    s_ack = 1'b1;
    settle();
    chk("rst_mid_ack",   32'(a_ack), 32'h0);
    chk("rst_mid_count", 32'(dut_a.count), 32'h0);
    tick();
    s_ack = 1'b0;
    settle();
    chk("rst_mid_count_after", 32'(dut_a.count), 32'h0);

    // Owner drops cyc with three outstanding on the limit-4 instance.
    do_reset();
    m_cyc = 2'b01;
    m_stb = 2'b01;
    tick();
    tick();
    tick();
    tick();
    m_cyc = 2'b00;
    m_stb = 2'b00;
    settle();
    chk("drop_count", 32'(dut_b.count), 32'h3);
    chk("drop_scyc",  32'(b_scyc), 32'h1);
    chk("drop_sstb",  32'(b_sstb), 32'h0);
    tick();
    settle();
    chk("drain_state", 32'(dut_b.state), 32'(DRAIN));
    chk("drain_scyc",  32'(b_scyc), 32'h1);
    chk("drain_stall", 32'(b_stall), 32'h3);
    s_ack = 1'b1;
    settle();
    chk("drain_ack1", 32'(b_ack), 32'h0);
    tick();
    settle();
    chk("drain_ack2", 32'(b_ack), 32'h0);
    tick();
    settle();
    chk("drain_ack3", 32'(b_ack), 32'h0);
    chk("drain_still", 32'(dut_b.state), 32'(DRAIN));
    tick();
    s_ack = 1'b0;
    settle();
    chk("drain_idle",  32'(dut_b.state), 32'(IDLE));
    chk("drain_grant", 32'(b_grant), 32'h0);
    chk("drain_scyc0", 32'(b_scyc), 32'h0);
    chk("drain_tmo",   32'(b_tmo), 32'h0);

`ifdef WB_ARB_TIMEOUT_EN
    // One accepted request, no ack: timeout after 8 waiting cycles.
    do_reset();
    m_cyc = 2'b01;
    m_stb = 2'b01;
    s_dat_i = 32'hCAFE_F00D;
    tick();
    tick();
    m_stb = 2'b00;
    for (int i = 1; i < 8; i++) begin
      tick();
      settle();
      chk("tmo_quiet", 32'(a_tmo), 32'h0);
    end
    tick();
    settle();
    chk("tmo_pulse", 32'(a_tmo), 32'h1);
    chk("tmo_ack",   32'(a_ack), 32'h1);
    chk("tmo_mdat",  a_mdat, 32'h0);
    tick();
    settle();
    chk("tmo_end",   32'(a_tmo), 32'h0);
    chk("tmo_count", 32'(dut_a.count), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
